tanh_result_checker: RTL and testbench

//  Hardware result checker that consumes the activation unit's output stream.

---
 rtl/tanh_result_checker.sv | 125 ++++++++++++
 tb/tb_tanh_result_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tanh_result_checker.sv
// tanh_result_checker: judges an activation-unit result stream against a
// golden ROM and keeps pass/fail statistics on-chip.
module tanh_result_checker #(
  parameter int BITWIDTH    = 18,
  parameter int MAX_SAMPLES = 40961,
  parameter int ADDR_W      = 16,
  parameter int TOLERANCE   = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                res_valid,
  input  logic [BITWIDTH-1:0] result,
  output logic                res_ready,
  output logic [ADDR_W-1:0]   gold_addr,
  input  logic [BITWIDTH-1:0] gold_data,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   err_count,
  output logic [BITWIDTH:0]   max_err,
  output logic [ADDR_W-1:0]   first_err_idx
);

  localparam int DW = BITWIDTH + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] ONES = '1;
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [DW-1:0]     TOL  = DW'(TOLERANCE);
  localparam logic [DW-1:0]     DONE_ = DW'(1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CMP,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] idx, idx_nx;
  logic              accept;
  logic              launch;
  logic              last;
  logic              mismatch;
  logic [DW-1:0]     diff;
  logic [DW-1:0]     absdiff;

  assign accept = (state == CMP) && res_valid;
  assign launch = start && ((state == IDLE) || (state == FIN));
  assign last   = idx == LAST;

  // One extra bit keeps the difference of two extremes representable.
  assign diff = {result[BITWIDTH-1], result}
              - {gold_data[BITWIDTH-1], gold_data};
  assign absdiff  = diff[DW-1] ? (~diff + DONE_) : diff;
  assign mismatch = absdiff > TOL;

  assign gold_addr = idx;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    unique case (state)
      IDLE, FIN: begin
        if (start) begin
          state_nx = FETCH;
          idx_nx   = '0;
        end
      end
      FETCH: state_nx = CMP;
      CMP: begin
        if (res_valid) begin
          if (last) begin
            state_nx = FIN;
          end else begin
            state_nx = FETCH;
            idx_nx   = idx + ONE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      res_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      res_ready <= state_nx == CMP;
      busy      <= (state_nx == FETCH) || (state_nx == CMP);
      done      <= state_nx == FIN;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      err_count     <= '0;
      max_err       <= '0;
      first_err_idx <= ONES;
    end else if (launch) begin
      err_count     <= '0;
      max_err       <= '0;
      first_err_idx <= ONES;
    end else if (accept) begin
      if (mismatch) begin
        if (err_count != ONES) begin
          err_count <= err_count + ONE;
        end
        if (err_count == '0) begin
          first_err_idx <= idx;
        end
      end
      if (absdiff > max_err) begin
        max_err <= absdiff;
      end
    end
  end

endmodule

// File: tb/tb_tanh_result_checker.sv
// Directed bench for tanh_result_checker: eight-sample runs with a
// behavioural golden ROM and hand-computed statistics.
module tb_tanh_result_checker;

  localparam int BW = 18;
  localparam int N  = 8;
  localparam int AW = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic res_valid = 1'b0;
  logic [BW-1:0] result = '0;
  logic [BW-1:0] gold_data = '0;

  logic [BW-1:0] rom     [N];
  logic [BW-1:0] res_vec [N];

  logic          ready0, ready2, ready3;
  logic          busy0, busy2, busy3;
  logic          done0, done2, done3;
  logic [AW-1:0] addr0, addr2, err0, err2, first0, first2;
  logic [2:0]    addr3, err3, first3;
  logic [BW:0]   max0, max2, max3;

  int n_run  = 0;
  int n_fail = 0;
  int cycles = 0;
  int acc_addr [$];

  always #5 clock = ~clock;

  always_ff @(posedge clock) gold_data <= rom[addr0[2:0]];

  tanh_result_checker #(
    .BITWIDTH(BW), .MAX_SAMPLES(N), .ADDR_W(AW), .TOLERANCE(0)
  ) u_t0 (
    .clock(clock), .reset(reset), .start(start),
    .res_valid(res_valid), .result(result), .res_ready(ready0),
    .gold_addr(addr0), .gold_data(gold_data),
    .busy(busy0), .done(done0), .err_count(err0),
    .max_err(max0), .first_err_idx(first0)
  );

  tanh_result_checker #(
    .BITWIDTH(BW), .MAX_SAMPLES(N), .ADDR_W(AW), .TOLERANCE(2)
  ) u_t2 (
    .clock(clock), .reset(reset), .start(start),
    .res_valid(res_valid), .result(result), .res_ready(ready2),
    .gold_addr(addr2), .gold_data(gold_data),
    .busy(busy2), .done(done2), .err_count(err2),
    .max_err(max2), .first_err_idx(first2)
  );

  tanh_result_checker #(
    .BITWIDTH(BW), .MAX_SAMPLES(N), .ADDR_W(3), .TOLERANCE(0)
  ) u_sat (
    .clock(clock), .reset(reset), .start(start),
    .res_valid(res_valid), .result(result), .res_ready(ready3),
    .gold_addr(addr3), .gold_data(gold_data),
    .busy(busy3), .done(done3), .err_count(err3),
    .max_err(max3), .first_err_idx(first3)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_clean();
    for (int i = 0; i < N; i++) res_vec[i] = rom[i];
  endtask

  // Producer: pulse start, then offer samples whenever not in a gap.
  task automatic run(input int lim, input int poke_at,
                     input int gap_at, input int gap_len);
    int  k;
    bit  acc;
    k = 0;
    acc_addr.delete();
    cycles = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (!done0 && cycles < lim) begin
      res_valid = (k < N) &&
                  !(cycles >= gap_at && cycles < gap_at + gap_len);
      result = res_vec[(k < N) ? k : N - 1];
      start  = (cycles == poke_at);
      acc    = ready0 && res_valid;
      if (acc) acc_addr.push_back(int'(addr0));
      @(posedge clock);
      if (acc) k++;
      cycles++;
      @(negedge clock);
    end
    res_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(ready0), 0);
    check({tag, "_busy"},  32'(busy0), 0);
    check({tag, "_done"},  32'(done0), 0);
    check({tag, "_addr"},  32'(addr0), 0);
    check({tag, "_err"},   32'(err0), 0);
    check({tag, "_max"},   32'(max0), 0);
    check({tag, "_first"}, 32'(first0), 32'hFFFF);
    check({tag, "_first3"}, 32'(first3), 7);
  endtask

  initial begin
    rom[0] = 18'h00000; rom[1] = 18'h1FFFF;
    rom[2] = 18'h20000; rom[3] = 18'h00123;
    rom[4] = 18'h3FF00; rom[5] = 18'h0ABCD;
    rom[6] = 18'h30000; rom[7] = 18'h12345;
    load_clean();

    repeat (3) @(negedge clock);
    check_reset("rst");
    reset = 1'b1;

    // 1: clean stream, start also pulsed on the final accept
    run(200, 15, -1, 0);
    check("t1_cycles", 32'(cycles), 16);
    check("t1_nacc", 32'(acc_addr.size()), 8);
    check("t1_err", 32'(err0), 0);
    check("t1_max", 32'(max0), 0);
    check("t1_first", 32'(first0), 32'hFFFF);
    repeat (2) @(negedge clock);
    check("t1_done_held", 32'(done0), 1);
    check("t1_busy", 32'(busy0), 0);
    check("t1_ready", 32'(ready0), 0);

    // 2: sample 5 off by +3
    load_clean();
    res_vec[5] = rom[5] + 18'd3;
    run(200, -1, -1, 0);
    check("t2_err", 32'(err0), 1);
    check("t2_first", 32'(first0), 5);
    check("t2_max", 32'(max0), 3);
    check("t2_err_tol2", 32'(err2), 1);

    // 3: +2 and -2 within tolerance 2
    load_clean();
    res_vec[2] = rom[2] + 18'd2;
    res_vec[6] = rom[6] - 18'd2;
    run(200, -1, -1, 0);
    check("t3_err_tol2", 32'(err2), 0);
    check("t3_max_tol2", 32'(max2), 2);
    check("t3_err_tol0", 32'(err0), 2);
    check("t3_first_tol0", 32'(first0), 2);

    // 4: most positive result against most negative golden
    load_clean();
    rom[0] = 18'h20000;
    res_vec[0] = 18'h1FFFF;
    run(200, -1, -1, 0);
    check("t4_max", 32'(max0), 262143);
    check("t4_err", 32'(err0), 1);
    check("t4_first", 32'(first0), 0);
    rom[0] = 18'h00000;

    // every sample off by one LSB: 3-bit counter saturates
    for (int i = 0; i < N; i++) res_vec[i] = rom[i] ^ 18'h1;
    run(200, -1, -1, 0);
    check("sat_err16", 32'(err0), 8);
    check("sat_err3", 32'(err3), 7);
    check("sat_first3", 32'(first3), 0);
    check("sat_max", 32'(max0), 1);
    check("sat_err_tol2", 32'(err2), 0);

    // 5: five-cycle valid gap plus start while busy
    load_clean();
    run(200, 5, 7, 5);
    check("t5_cycles", 32'(cycles), 21);
    check("t5_nacc", 32'(acc_addr.size()), 8);
    for (int i = 0; i < N; i++) begin
      if (i < acc_addr.size())
        check($sformatf("t5_addr%0d", i), 32'(acc_addr[i]), 32'(i));
    end
    check("t5_err", 32'(err0), 0);
    check("t5_max", 32'(max0), 0);
    check("t5_first", 32'(first0), 32'hFFFF);
    check("t5_done", 32'(done0), 1);

    // 6: reset mid-run after one logged error, then a clean run
    load_clean();
    res_vec[1] = rom[1] ^ 18'h1;
    run(8, -1, -1, 0);
    check("t6_busy_mid", 32'(busy0), 1);
    check("t6_err_mid", 32'(err0), 1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check_reset("t6_rst");
    load_clean();
    run(200, -1, -1, 0);
    check("t6_cycles", 32'(cycles), 16);
    check("t6_err", 32'(err0), 0);
    check("t6_done", 32'(done0), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
